// File: rtl/minmax_seq.sv
// minmax_seq: streams a burst of 3-bit samples through one shared G/E/L comparator to find min/max and their positions.
// Define MINMAX_LAST_TIE_EN to report the latest occurrence on ties (default: earliest).
module minmax_seq #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [2:0]       in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             empty,
    output logic [2:0]       max_val,
    output logic [2:0]       min_val,
    output logic [LEN_W-1:0] max_idx,
    output logic [LEN_W-1:0] min_idx
);
    typedef enum logic [2:0] {IDLE, WAIT, CMP_MAX, CMP_MIN, DONE} state_t;
`ifdef MINMAX_LAST_TIE_EN
    localparam bit LAST_TIE = 1'b1;
`else
    localparam bit LAST_TIE = 1'b0;
`endif
    state_t state, nxt;
    logic [LEN_W-1:0] len_r, count, sidx, cnt_inc;
    logic [2:0] sreg, y;
    logic g, e, l, xfer;
    assign in_ready = state == WAIT;
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign xfer = in_valid && in_ready;
    assign cnt_inc = count + 1'b1;
    // the single comparator: x is always the latched sample, y follows the phase
    assign y = state == CMP_MAX ? max_val : min_val;
    assign g = sreg > y;
    assign e = sreg == y;
    assign l = sreg < y;
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = start ? (len == '0 ? DONE : WAIT) : IDLE;
            WAIT: nxt = !xfer ? WAIT : count != '0 ? CMP_MAX : len_r == LEN_W'(1) ? DONE : WAIT;
            CMP_MAX: nxt = CMP_MIN;
            CMP_MIN: nxt = cnt_inc == len_r ? DONE : WAIT;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            len_r <= '0;
            count <= '0;
            sidx <= '0;
            sreg <= '0;
            empty <= 1'b0;
            max_val <= '0;
            min_val <= '0;
            max_idx <= '0;
            min_idx <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    len_r <= len;
                    count <= '0;
                    empty <= len == '0;
                    max_val <= '0;
                    min_val <= '0;
                    max_idx <= '0;
                    min_idx <= '0;
                end
                WAIT: if (xfer) begin
                    if (count == '0) begin
                        max_val <= in_data;
                        min_val <= in_data;
                        max_idx <= '0;
                        min_idx <= '0;
                        count <= LEN_W'(1);
                    end else begin
                        sreg <= in_data;
                        sidx <= count;
                    end
                end
                CMP_MAX: begin
                    if (g) max_val <= sreg;
                    if (g || (e && LAST_TIE)) max_idx <= sidx;
                end
                CMP_MIN: begin
                    if (l) min_val <= sreg;
                    if (l || (e && LAST_TIE)) min_idx <= sidx;
                    count <= cnt_inc;
                end
                default: ;
            endcase
        end
    end
endmodule
